// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
//   arb_port_e : identifies the fetch or data port
//   LANE_BITS  : number of address bits selecting a 32-bit lane in a 128-bit line
//   arb_rsp_t  : response pipeline entry (valid, port, lane)
package mem_arb_pkg;

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } arb_port_e;

    localparam int LANE_BITS = 2;
    localparam int NUM_LANES = 1 << LANE_BITS;

    typedef struct packed {
        logic                 valid;
        arb_port_e            port;
        logic [LANE_BITS-1:0] lane;
    } arb_rsp_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   instr_req_i/data_req_i : requests
//   instr_gnt_o/data_gnt_o : combinational grants (forced 0 in reset)
// The last_win register only moves on contention cycles, so an
// uncontended grant never disturbs the fairness order.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic instr_req_i,
    input  logic data_req_i,
    output logic instr_gnt_o,
    output logic data_gnt_o
);

    arb_port_e last_win_q;
    arb_port_e last_win_d;
    logic      contention;

    assign contention = instr_req_i & data_req_i;

    always_comb begin
        instr_gnt_o = 1'b0;
        data_gnt_o  = 1'b0;
        last_win_d  = last_win_q;
        if (!rst_i) begin
            if (contention) begin
                // Under contention the port that did not win last time goes.
                if (last_win_q == PORT_INSTR) begin
                    data_gnt_o = 1'b1;
                    last_win_d = PORT_DATA;
                end else begin
                    instr_gnt_o = 1'b1;
                    last_win_d  = PORT_INSTR;
                end
            end else begin
                instr_gnt_o = instr_req_i;
                data_gnt_o  = data_req_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_win_q <= PORT_INSTR;
        end else begin
            last_win_q <= last_win_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port 128-bit synchronous RAM between the fetch and
// data ports of the core.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   instr_*           : fetch port (req/addr in, gnt/rvalid/128-bit rdata out)
//   data_*            : load/store port (req/addr/we/be/wdata in, gnt/rvalid/rdata out)
//   mem_*             : RAM macro port; read data returns one cycle after mem_req_o
//   conflict_cnt_o    : saturating count of cycles where both ports requested
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 22,
    parameter int LINE_WIDTH = 128,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  instr_req_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [LINE_WIDTH-1:0] instr_rdata_o,
    input  logic                  data_req_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [31:0]           data_wdata_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [31:0]           data_rdata_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-5:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [15:0]           mem_be_o,
    output logic [LINE_WIDTH-1:0] mem_wdata_o,
    input  logic [LINE_WIDTH-1:0] mem_rdata_i,
    output logic [CNT_WIDTH-1:0]  conflict_cnt_o
);

    logic [LANE_BITS-1:0] data_lane;
    logic [15:0]          data_be_shifted;
    arb_rsp_t             rsp_q;
    arb_rsp_t             rsp_d;
    logic                 rsp_store_q;
    logic                 rsp_store_d;
    logic [CNT_WIDTH-1:0] conflict_q;
    logic [CNT_WIDTH-1:0] conflict_d;
    logic [31:0]          lane_words [NUM_LANES];
    logic                 unused_addr_bits;

    // Byte offset within the line is irrelevant to a line-wide RAM.
    assign unused_addr_bits = ^{instr_addr_i[3:0], data_addr_i[1:0]};

    rr_arb2 u_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .instr_req_i (instr_req_i),
        .data_req_i  (data_req_i),
        .instr_gnt_o (instr_gnt_o),
        .data_gnt_o  (data_gnt_o)
    );

    assign data_lane       = data_addr_i[LANE_BITS+1:2];
    assign data_be_shifted = {12'b0, data_be_i} << {data_lane, 2'b00};

    // RAM drive comes from whichever port won; idle drives all zeros.
    always_comb begin
        mem_req_o   = instr_gnt_o | data_gnt_o;
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (instr_gnt_o) begin
            mem_addr_o = instr_addr_i[ADDR_WIDTH-1:4];
        end else if (data_gnt_o) begin
            mem_addr_o  = data_addr_i[ADDR_WIDTH-1:4];
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_shifted;
            // Replicated word; the byte enables pick the live lane.
            mem_wdata_o = {NUM_LANES{data_wdata_i}};
        end
    end

    always_comb begin
        rsp_d.valid = instr_gnt_o | data_gnt_o;
        rsp_d.port  = data_gnt_o ? PORT_DATA : PORT_INSTR;
        rsp_d.lane  = data_lane;
        rsp_store_d = data_gnt_o & data_we_i;
    end

    always_comb begin
        conflict_d = conflict_q;
        if (instr_req_i && data_req_i && (conflict_q != {CNT_WIDTH{1'b1}})) begin
            conflict_d = conflict_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_q       <= '0;
            rsp_store_q <= 1'b0;
            conflict_q  <= '0;
        end else begin
            rsp_q       <= rsp_d;
            rsp_store_q <= rsp_store_d;
            conflict_q  <= conflict_d;
        end
    end

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lanes
        assign lane_words[gi] = mem_rdata_i[gi*32 +: 32];
    end

    // Gating with rst_i drops a response that was pending when reset arrived.
    always_comb begin
        instr_rvalid_o = rsp_q.valid && (rsp_q.port == PORT_INSTR) && !rst_i;
        data_rvalid_o  = rsp_q.valid && (rsp_q.port == PORT_DATA) && !rst_i;
        instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
        // Stores respond with zero data.
        data_rdata_o   = (data_rvalid_o && !rsp_store_q) ? lane_words[rsp_q.lane] : '0;
    end

    assign conflict_cnt_o = conflict_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int AW = 22;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          instr_req;
    logic [AW-1:0] instr_addr;
    logic          instr_gnt, instr_rvalid;
    logic [127:0]  instr_rdata;
    logic          data_req;
    logic [AW-1:0] data_addr;
    logic          data_we;
    logic [3:0]    data_be;
    logic [31:0]   data_wdata;
    logic          data_gnt, data_rvalid;
    logic [31:0]   data_rdata;
    logic          mem_req;
    logic [AW-5:0] mem_addr;
    logic          mem_we;
    logic [15:0]   mem_be;
    logic [127:0]  mem_wdata;
    logic [127:0]  mem_rdata = '0;
    logic [CW-1:0] conflict_cnt;

    logic [127:0]  ram [64];

    int checks_cnt = 0;
    int fail_cnt   = 0;

    localparam logic [127:0] LINE1 = 128'h44443333_22221111_BBBB0000_AAAA5555;
    localparam logic [127:0] LINE8 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(128), .CNT_WIDTH(CW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .instr_req_i    (instr_req),
        .instr_addr_i   (instr_addr),
        .instr_gnt_o    (instr_gnt),
        .instr_rvalid_o (instr_rvalid),
        .instr_rdata_o  (instr_rdata),
        .data_req_i     (data_req),
        .data_addr_i    (data_addr),
        .data_we_i      (data_we),
        .data_be_i      (data_be),
        .data_wdata_i   (data_wdata),
        .data_gnt_o     (data_gnt),
        .data_rvalid_o  (data_rvalid),
        .data_rdata_o   (data_rdata),
        .mem_req_o      (mem_req),
        .mem_addr_o     (mem_addr),
        .mem_we_o       (mem_we),
        .mem_be_o       (mem_be),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata),
        .conflict_cnt_o (conflict_cnt)
    );

    // Behavioural single-port RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_req) begin
            mem_rdata <= ram[mem_addr[5:0]];
            if (mem_we) begin
                for (int b = 0; b < 16; b++) begin
                    if (mem_be[b]) ram[mem_addr[5:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = {4{32'h1000_0000 + i}};
        ram[1] = LINE1;
        ram[8] = LINE8;

        rst = 1'b1; instr_req = 1'b1; instr_addr = 22'h80;
        data_req = 1'b1; data_addr = '0; data_we = 1'b0; data_be = 4'h0; data_wdata = '0;
        tick(); tick();
        check_eq("rst_instr_gnt", instr_gnt, 0);
        check_eq("rst_data_gnt", data_gnt, 0);
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_rvalid", {instr_rvalid, data_rvalid}, 0);
        check_eq("rst_cnt", conflict_cnt, 0);
        instr_req = 1'b0; data_req = 1'b0;
        tick();
        rst = 1'b0;
        #1;

        // Instruction-only read at 0x80.
        instr_req = 1'b1; instr_addr = 22'h80;
        #1;
        check_eq("if_gnt", {instr_gnt, data_gnt}, 2'b10);
        check_eq("if_mem_addr", mem_addr, 18'h8);
        check_eq("if_mem_we", mem_we, 0);
        tick();
        instr_req = 1'b0;
        #1;
        check_eq("if_rvalid", {instr_rvalid, data_rvalid}, 2'b10);
        check_eq("if_rdata", instr_rdata, LINE8);

        // Store 0xDEADBEEF, be 0011, at 0x8C (line 8, lane 3).
        data_req = 1'b1; data_addr = 22'h8C; data_we = 1'b1; data_be = 4'b0011; data_wdata = 32'hDEADBEEF;
        #1;
        check_eq("st_gnt", {instr_gnt, data_gnt}, 2'b01);
        check_eq("st_mem_be", mem_be, 16'h3000);
        check_eq("st_mem_addr", mem_addr, 18'h8);
        check_eq("st_mem_we", mem_we, 1);
        check_eq("st_mem_wdata", mem_wdata, {4{32'hDEADBEEF}});
        tick();
        data_req = 1'b0; data_we = 1'b0;
        #1;
        check_eq("st_rvalid", {instr_rvalid, data_rvalid}, 2'b01);
        check_eq("st_rdata", data_rdata, 0);

        // Load back from 0x8C: low half new, high half unchanged.
        data_req = 1'b1; data_addr = 22'h8C; data_be = 4'hF;
        #1;
        check_eq("ld_mem_we", mem_we, 0);
        tick();
        data_req = 1'b0;
        #1;
        check_eq("ld_rvalid", data_rvalid, 1);
        check_eq("ld_rdata", data_rdata, 32'h0123BEEF);

        // Contention for 4 cycles: D, I, D, I. Data loads lane 1 of line 1.
        instr_req = 1'b1; instr_addr = 22'h80;
        data_req = 1'b1; data_addr = 22'h14; data_we = 1'b0; data_be = 4'hF;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq($sformatf("rr_gnt%0d", k), {instr_gnt, data_gnt}, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            check_eq($sformatf("rr_rvalid%0d", k), {instr_rvalid, data_rvalid}, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k % 2 == 0) check_eq($sformatf("rr_lane1_%0d", k), data_rdata, 32'hBBBB0000);
            else            check_eq($sformatf("rr_iline%0d", k), instr_rdata, 128'h0123BEEF_89ABCDEF_FEDCBA98_76543210);
        end
        check_eq("rr_cnt4", conflict_cnt, 4);

        // One more contention (DATA wins), then reset the cycle after.
        #1;
        check_eq("pre_rst_gnt", {instr_gnt, data_gnt}, 2'b01);
        tick();
        rst = 1'b1;
        #1;
        check_eq("rst_drop_rvalid", {instr_rvalid, data_rvalid}, 0);
        check_eq("rst_hold_gnt", {instr_gnt, data_gnt}, 0);
        tick();
        rst = 1'b0;
        #1;
        check_eq("post_rst_cnt", conflict_cnt, 0);
        check_eq("post_rst_rvalid", {instr_rvalid, data_rvalid}, 0);
        check_eq("post_rst_gnt", {instr_gnt, data_gnt}, 2'b01);

        // Saturation: 20 contention cycles at CNT_WIDTH = 4.
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k == 13) check_eq("sat_cnt14", conflict_cnt, 14);
        end
        check_eq("sat_cnt", conflict_cnt, 4'hF);

        // Idle: every RAM output is zero, no responses follow.
        instr_req = 1'b0; data_req = 1'b0;
        #1;
        check_eq("idle_mem", {mem_req, mem_we, mem_be, mem_addr}, 0);
        check_eq("idle_wdata", mem_wdata, 0);
        tick();
        tick();
        check_eq("idle_rvalid", {instr_rvalid, data_rvalid}, 0);
        check_eq("idle_rdata", {instr_rdata, data_rdata}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
